// File: rtl/frame_bcd_counter_pkg.sv
// Shared video constants used by the sync generator, the digit renderer and the
// frame BCD counter.
package frame_bcd_counter_pkg;

  // Bits per BCD digit and the largest legal digit value.
  localparam int unsigned          BcdWidth = 4;
  localparam logic [BcdWidth-1:0] BcdMax   = 4'd9;

  // Width of the beam position buses.
  localparam int unsigned PosWidth = 10;

  // First vertical blanking line; shared with the sync generator and renderer.
  localparam int unsigned VDisplayDefault = 480;

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the frame counter.
//
// Ports:
//   clk_i    pixel clock
//   rst_i    synchronous active-high reset
//   clear_i  synchronous clear to 0 (beats carry_i)
//   carry_i  increment request from the digit below
//   digit_o  registered digit value, 0..9
//   carry_o  increment request to the digit above (digit is 9 and carry_i)
module bcd_digit_cell
  import frame_bcd_counter_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear_i,
  input  logic                carry_i,
  output logic [BcdWidth-1:0] digit_o,
  output logic                carry_o
);

  logic [BcdWidth-1:0] digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clear_i) begin
      digit_d = '0;
    end else if (carry_i) begin
      digit_d = (digit_q == BcdMax) ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;
  // Combinational ripple so a multi-digit carry settles within one cycle.
  assign carry_o = carry_i && (digit_q == BcdMax);

endmodule

// File: rtl/frame_bcd_counter.sv
// Frame-driven BCD counter feeding the bitmapped digit renderer.
// A frame tick fires on the edge ending the cycle where the beam sits at
// (H_TRIGGER, V_DISPLAY), i.e. at the start of vertical blanking. Every
// FRAMES_PER_COUNT enabled ticks the BCD count increments by one, so digit
// changes are never visible mid-frame.
//
// Ports:
//   i_clk         pixel clock shared with the sync generator
//   i_rst         synchronous active-high reset
//   i_hpos        beam horizontal position
//   i_vpos        beam vertical position
//   i_enable      low: prescaler and digits hold (ticks still fire)
//   i_clear       synchronous clear of digits and prescaler
//   o_digits      BCD count, digit 0 in [3:0], least significant
//   o_frame_tick  one-cycle pulse per frame
//   o_overflow    one-cycle pulse when the count wraps from all 9s to all 0s
module frame_bcd_counter
  import frame_bcd_counter_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned FRAMES_PER_COUNT = 60,
  parameter int unsigned V_DISPLAY        = VDisplayDefault,
  parameter int unsigned H_TRIGGER        = 0
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic [PosWidth-1:0]            i_hpos,
  input  logic [PosWidth-1:0]            i_vpos,
  input  logic                           i_enable,
  input  logic                           i_clear,
  output logic [BcdWidth*NUM_DIGITS-1:0] o_digits,
  output logic                           o_frame_tick,
  output logic                           o_overflow
);

  localparam int unsigned PsWidth =
      (FRAMES_PER_COUNT > 1) ? $clog2(FRAMES_PER_COUNT) : 1;
  localparam logic [PsWidth-1:0]  PsMax = PsWidth'(FRAMES_PER_COUNT - 1);
  localparam logic [PosWidth-1:0] HTrig = PosWidth'(H_TRIGGER);
  localparam logic [PosWidth-1:0] VTrig = PosWidth'(V_DISPLAY);

  logic               match;
  logic               advance;
  logic               rollover;
  logic [PsWidth-1:0] ps_q, ps_d;
  logic               tick_q;
  logic               overflow_q, overflow_d;
  logic [NUM_DIGITS:0] carry;

  assign match    = (i_hpos == HTrig) && (i_vpos == VTrig);
  assign advance  = match && i_enable;
  assign rollover = advance && (ps_q == PsMax);

  always_comb begin
    ps_d = ps_q;
    if (i_clear) begin
      ps_d = '0;
    end else if (advance) begin
      ps_d = (ps_q == PsMax) ? '0 : ps_q + 1'b1;
    end
  end

  // Carry out of the top digit means every digit was 9: the count wraps.
  assign overflow_d = carry[NUM_DIGITS] && !i_clear;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ps_q       <= '0;
      tick_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      tick_q     <= match;
      overflow_q <= overflow_d;
    end
  end

  assign carry[0] = rollover;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit_cell u_cell (
      .clk_i   (i_clk),
      .rst_i   (i_rst),
      .clear_i (i_clear),
      .carry_i (carry[g]),
      .digit_o (o_digits[g*BcdWidth +: BcdWidth]),
      .carry_o (carry[g+1])
    );
  end

  assign o_frame_tick = tick_q;
  assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_frame_bcd_counter.sv
// Bench for frame_bcd_counter: two instances (FRAMES_PER_COUNT 3 and 1) share
// stimulus. Each driven cycle pushes the expected next outputs of both onto a
// scoreboard queue; they are popped and compared on the following falling edge.
module tb_frame_bcd_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic       en = 1'b0;
  logic       clr = 1'b0;

  logic [15:0] dig3, dig1;
  logic        tick3, tick1, ovf3, ovf1;

  always #5 clk = ~clk;

  frame_bcd_counter #(
    .NUM_DIGITS       (4),
    .FRAMES_PER_COUNT (3),
    .V_DISPLAY        (480),
    .H_TRIGGER        (0)
  ) u_dut3 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_hpos       (hpos),
    .i_vpos       (vpos),
    .i_enable     (en),
    .i_clear      (clr),
    .o_digits     (dig3),
    .o_frame_tick (tick3),
    .o_overflow   (ovf3)
  );

  frame_bcd_counter #(
    .NUM_DIGITS       (4),
    .FRAMES_PER_COUNT (1),
    .V_DISPLAY        (480),
    .H_TRIGGER        (0)
  ) u_dut1 (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_hpos       (hpos),
    .i_vpos       (vpos),
    .i_enable     (en),
    .i_clear      (clr),
    .o_digits     (dig1),
    .o_frame_tick (tick1),
    .o_overflow   (ovf1)
  );

  typedef struct {
    logic [15:0] d3;
    logic        t3;
    logic        o3;
    logic [15:0] d1;
    logic        t1;
    logic        o1;
  } exp_t;

  exp_t sb_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference state: prescaler and a plain integer count per instance.
  int ps3 = 0, cnt3 = 0, ps1 = 0, cnt1 = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[3:0]   = 4'(v % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[15:12] = 4'((v / 1000) % 10);
    return r;
  endfunction

  task automatic model(input int fpc, input logic r, input logic m, input logic e,
                       input logic c, inout int ps, inout int cnt, output logic ovf);
    ovf = 1'b0;
    if (r) begin
      ps  = 0;
      cnt = 0;
    end else if (c) begin
      ps  = 0;
      cnt = 0;
    end else if (m && e) begin
      if (ps == fpc - 1) begin
        ps = 0;
        if (cnt == 9999) begin
          cnt = 0;
          ovf = 1'b1;
        end else begin
          cnt++;
        end
      end else begin
        ps++;
      end
    end
  endtask

  task automatic compare_head();
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check("digits_f3", 32'(dig3), 32'(x.d3));
      check("tick_f3",   32'(tick3), 32'(x.t3));
      check("ovf_f3",    32'(ovf3), 32'(x.o3));
      check("digits_f1", 32'(dig1), 32'(x.d1));
      check("tick_f1",   32'(tick1), 32'(x.t1));
      check("ovf_f1",    32'(ovf1), 32'(x.o1));
    end
  endtask

  task automatic step(input logic r, input logic [9:0] h, input logic [9:0] v,
                      input logic e, input logic c);
    exp_t x;
    logic m;
    logic o;
    @(negedge clk);
    compare_head();
    rst  = r;
    hpos = h;
    vpos = v;
    en   = e;
    clr  = c;
    m = (h == 10'd0) && (v == 10'd480);
    model(3, r, m, e, c, ps3, cnt3, o);
    x.d3 = to_bcd(cnt3);
    x.t3 = m && !r;
    x.o3 = o;
    model(1, r, m, e, c, ps1, cnt1, o);
    x.d1 = to_bcd(cnt1);
    x.t1 = m && !r;
    x.o1 = o;
    sb_q.push_back(x);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 10'd5, 10'd100, 1'b1, 1'b0);
  endtask

  task automatic tick(input logic e, input logic c);
    step(1'b0, 10'd0, 10'd480, e, c);
  endtask

  initial begin
    // Reset and settle.
    step(1'b1, 10'd0, 10'd0, 1'b1, 1'b0);
    step(1'b1, 10'd0, 10'd0, 1'b1, 1'b0);
    idle(3);

    // Count to 0x0042 on the divide-by-1 instance, then reset mid-count.
    repeat (42) tick(1'b1, 1'b0);
    idle(1);
    step(1'b1, 10'd0, 10'd480, 1'b1, 1'b0);
    step(1'b1, 10'd0, 10'd480, 1'b1, 1'b0);
    idle(2);

    // Prescale: six separated frame ticks.
    repeat (6) begin
      tick(1'b1, 1'b0);
      idle(3);
    end

    // Carry ripple up to 0x0099 and then 0x0100 in one step.
    repeat (93) tick(1'b1, 1'b0);
    idle(2);
    tick(1'b1, 1'b0);
    idle(2);

    // Enable low: ticks pulse, count holds.
    repeat (5) begin
      tick(1'b0, 1'b0);
      idle(2);
    end

    // Bring divide-by-3 prescaler to its rollover value, then clear on the match.
    tick(1'b1, 1'b0);
    idle(1);
    tick(1'b1, 1'b1);
    idle(1);
    repeat (4) begin
      tick(1'b1, 1'b0);
      idle(1);
    end

    // Clear on a non-match cycle.
    step(1'b0, 10'd5, 10'd100, 1'b1, 1'b1);
    idle(1);

    // Reach 9999, clear on the wrapping tick: no overflow.
    repeat (9999) tick(1'b1, 1'b0);
    idle(1);
    tick(1'b1, 1'b1);
    idle(2);

    // Reach 9999 again and wrap.
    repeat (9999) tick(1'b1, 1'b0);
    idle(2);
    tick(1'b1, 1'b0);
    idle(3);
    tick(1'b1, 1'b0);
    idle(2);

    // Frame sweep with the trigger line removed.
    for (int v = 0; v < 525; v++) begin
      for (int h = 0; h < 800; h += 32) begin
        step(1'b0, 10'(h), 10'((v > 479) ? 479 : v), 1'b1, 1'b0);
      end
    end
    // Trigger line and neighbour line, off the trigger column.
    for (int h = 1; h <= 40; h++) step(1'b0, 10'(h), 10'd480, 1'b1, 1'b0);
    step(1'b0, 10'd0, 10'd481, 1'b1, 1'b0);
    step(1'b0, 10'd0, 10'd479, 1'b1, 1'b0);
    idle(2);

    @(negedge clk);
    compare_head();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/frame_bcd_counter.md
Name: frame_bcd_counter

Overview:
- Upstream value source for the bitmapped digit renderer; watches the sync generator's beam position and produces a multi-digit BCD count.
- Count advances once every FRAMES_PER_COUNT frames, so digits act as an on-screen frame/seconds counter.
- All updates happen at the start of vertical blanking, so the renderer never sees digits change mid-frame.

Parameters:
- NUM_DIGITS, 4, number of BCD digits; o_digits width is 4*NUM_DIGITS.
- FRAMES_PER_COUNT, 60, frame ticks per count increment; legal range is 1 or greater.
- V_DISPLAY, 480, first vblank line; a frame tick fires on this line.
- H_TRIGGER, 0, hpos on line V_DISPLAY at which the frame tick fires.

Ports:
- i_clk  in  1  pixel clock shared with the sync generator.
- i_rst  in  1  reset, synchronous and active-high.
- i_hpos  in  10  beam horizontal position from the sync generator.
- i_vpos  in  10  beam vertical position from the sync generator.
- i_enable  in  1  when low, the prescaler and digits hold; frame ticks still occur.
- i_clear  in  1  synchronous clear of the digits and prescaler.
- o_digits  out  4*NUM_DIGITS  BCD count; digit 0 is in bits [3:0] and is least significant.
- o_frame_tick  out  1  one-cycle pulse per frame.
- o_overflow  out  1  one-cycle pulse when the count wraps from all 9s to all 0s.

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is synchronous and active-high.
- Reset: all outputs and internal state are 0. This covers o_digits, o_frame_tick, o_overflow and the prescaler. Reset has priority over every other input.
- Match condition: the cycle where i_hpos==H_TRIGGER and i_vpos==V_DISPLAY.
- Frame tick and register updates: on the edge that ends the match cycle:
  - o_frame_tick goes to 1 for exactly one cycle.
  - The prescaler and digit updates take effect on that same edge.
  - As a result, a changed o_digits appears in the same cycle as o_frame_tick=1.
- Prescaler: width is clog2(FRAMES_PER_COUNT), with a minimum of 1 bit. On a tick with i_enable=1:
  - if prescaler==FRAMES_PER_COUNT-1, the prescaler goes to 0 and the digits increment;
  - otherwise the prescaler increments by 1.
- FRAMES_PER_COUNT=1: the digits increment on every tick.
- Digit increment is a BCD ripple from digit 0 upward:
  - a digit holding 9 with carry-in goes to 0 and passes carry out;
  - any other digit with carry-in adds 1 and stops the carry.
  - Ripple is combinational within one cycle; no multi-cycle carry.
- Wrap: all digits 9 plus an increment gives all digits 0, and o_overflow=1 for that one cycle, coincident with o_frame_tick.
- i_enable=0: the prescaler and digits hold; o_frame_tick still pulses; o_overflow stays 0.
- i_clear=1 on a cycle: on the next edge the digits and prescaler go to 0 and o_overflow=0.
  - Clear beats a simultaneous increment.
  - o_frame_tick is unaffected by clear.
- Match held for consecutive cycles: cannot occur with a legal sync generator. If forced, each matching cycle produces a tick.
- Illegal BCD states (digit above 9) are unreachable; no recovery logic is required.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared video package holds:
  - the BCD digit width constant (4);
  - BCD max value constant (9);
  - V_DISPLAY default (480), shared with the sync generator and the renderer.
- Sub-module bcd_digit_cell:
  - one 4-bit BCD register with inputs clk, rst, clear, carry-in;
  - outputs digit value and carry-out (digit==9 and carry-in);
  - instantiated NUM_DIGITS times in a generate loop; digit 0's carry-in is the prescaler rollover AND i_enable.

Test Plan:
- Reset: assert i_rst for 2 cycles mid-count (digits=0x0042) -> next cycle o_digits=0x0000, o_frame_tick=0, o_overflow=0.
- Prescale (FRAMES_PER_COUNT=3): drive 6 matches at hpos=0, vpos=480 -> 6 tick pulses; o_digits goes 0000 to 0001 on the 3rd tick and to 0002 on the 6th, each change coincident with its tick.
- Carry ripple (FRAMES_PER_COUNT=1): preload to 0x0099 via increments, one more tick -> o_digits=0x0100 in a single cycle; no intermediate 0x0090 is visible.
- Wrap: count to 0x9999, one more tick -> o_digits=0x0000, o_overflow=1 for exactly 1 cycle, aligned with o_frame_tick.
- Enable/clear: i_enable=0 across 5 ticks -> digits unchanged while ticks still pulse; i_clear=1 in the match cycle with rollover due -> o_digits=0x0000, prescaler=0, no overflow.
- Non-match: sweep a full 800x525 frame with the match removed (vpos capped at 479) -> no o_frame_tick and o_digits constant.
